// File: rtl/instr_encoder.sv
// instr_encoder: turns symbolic MIPS instruction requests into 32-bit machine
// words paired with sequential word-aligned byte addresses, for loading
// instruction memory. One output register with a valid/ready handshake
// supports back-to-back throughput of one word per cycle.
//
// state  | meaning
// S_RUN  | accepting requests and emitting words
// S_DONE | last request has drained; waiting for start
module instr_encoder #(
  parameter int ADDR_W   = 8,
  parameter int BASE_IDX = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W+1:0] out_addr,
  output logic [31:0]       out_instr,
  output logic              done,
  output logic              err,
  output logic              wrapped,
  output logic [ADDR_W:0]   count
);

  typedef enum logic {S_RUN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_IDX);
  localparam logic [ADDR_W-1:0] IDX_MAX   = '1;
  localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_next;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_after;
  logic              last_pending;
  logic              drain;
  logic              accept;
  logic              legal;
  logic [31:0]       word;

  assign drain     = out_valid && out_ready;
  assign accept    = in_valid && in_ready;
  assign legal     = (in_kind <= 4'd9);
  // A word loaded in the same cycle as a drain takes the next slot's address.
  assign idx_after = drain ? idx + ADDR_W'(1) : idx;

  // Encode the request fields into a machine word; illegal kinds yield zero.
  always_comb begin
    word = '0;
    case (in_kind)
      4'd1:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
      4'd2:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
      4'd3:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100100};
      4'd4:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100101};
      4'd5:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b101010};
      4'd6:    word = {6'b100011, in_rs, in_rt, in_imm};
      4'd7:    word = {6'b101011, in_rs, in_rt, in_imm};
      4'd8:    word = {6'b000100, in_rs, in_rt, in_imm};
      4'd9:    word = {6'b001000, in_rs, in_rt, in_imm};
      default: word = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_next;
  end

  // Leave RUN once the final request has been accepted and its word is gone.
  always_comb begin
    state_next = state;
    case (state)
      S_RUN:  if (last_pending && (!out_valid || drain)) state_next = S_DONE;
      S_DONE: if (start) state_next = S_RUN;
      default: state_next = S_RUN;
    endcase
  end

  // Handshake and status decode from state.
  always_comb begin
    in_ready = (state == S_RUN) && (!out_valid || out_ready);
    done     = (state == S_DONE);
  end

  // Output register, address index, counters and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx          <= BASE;
      count        <= '0;
      err          <= 1'b0;
      wrapped      <= 1'b0;
      last_pending <= 1'b0;
      out_valid    <= 1'b0;
      out_instr    <= '0;
      out_addr     <= {BASE, 2'b00};
    end else if ((state == S_DONE) && start) begin
      idx          <= BASE;
      count        <= '0;
      err          <= 1'b0;
      wrapped      <= 1'b0;
      last_pending <= 1'b0;
      out_addr     <= {BASE, 2'b00};
    end else begin
      if (drain) begin
        idx <= idx_after;
        if (count != COUNT_MAX) count <= count + (ADDR_W+1)'(1);
        if (idx == IDX_MAX) wrapped <= 1'b1;
      end
      if (accept && legal) begin
        out_valid <= 1'b1;
        out_instr <= word;
        out_addr  <= {idx_after, 2'b00};
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      if (accept && !legal) err <= 1'b1;
      if (accept && in_last) last_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed scenarios with literal expectations
// followed by randomized traffic, all checked against a word-count based
// reference model.
module tb_instr_encoder;

  localparam int AW   = 2;
  localparam int BASE = 0;
  localparam int NW   = 1 << AW;
  localparam int unsigned FUNCT_TAB[5] = '{32, 34, 36, 37, 42};
  localparam int unsigned OP_TAB[4]    = '{35, 43, 4, 8};

  logic          clk = 0;
  logic          rst = 1;
  logic          start = 0;
  logic          in_valid = 0;
  logic          in_ready;
  logic [3:0]    in_kind = 0;
  logic [4:0]    in_rs = 0, in_rt = 0, in_rd = 0;
  logic [15:0]   in_imm = 0;
  logic          in_last = 0;
  logic          out_valid;
  logic          out_ready = 1;
  logic [AW+1:0] out_addr;
  logic [31:0]   out_instr;
  logic          done, err, wrapped;
  logic [AW:0]   count;

  int n_cmp = 0;
  int n_bad = 0;

  instr_encoder #(.ADDR_W(AW), .BASE_IDX(BASE)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_instr(out_instr), .done(done), .err(err),
    .wrapped(wrapped), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_encode(input int unsigned kind, input int unsigned rs,
                                             input int unsigned rt, input int unsigned rd,
                                             input int unsigned imm);
    if (kind == 0) return 32'h0;
    if (kind <= 5) return 32'((rs << 21) | (rt << 16) | (rd << 11) | FUNCT_TAB[kind-1]);
    return 32'((OP_TAB[kind-6] << 26) | (rs << 21) | (rt << 16) | imm);
  endfunction

  // Reference model: state expressed as words accepted / drained since the
  // program began; one word may be outstanding at a time.
  bit          m_known = 0;
  bit          m_done = 0, m_lp = 0, m_err = 0;
  int          m_acc = 0, m_dr = 0;
  logic [31:0] m_instr = 0;
  int          m_addr = 0;

  always @(negedge clk) begin
    bit ov, irdy, drn, acc, lp_old;
    ov   = m_acc > m_dr;
    irdy = !m_done && (!ov || out_ready);
    drn  = ov && out_ready;
    acc  = in_valid && irdy;
    if (m_known) begin
      chk("in_ready", 32'(in_ready), 32'(irdy));
      chk("out_valid", 32'(out_valid), 32'(ov));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      chk("wrapped", 32'(wrapped), 32'((BASE + m_dr) >= NW));
      chk("count", 32'(count), 32'((m_dr < NW) ? m_dr : NW));
      if (ov) begin
        chk("out_addr", 32'(out_addr), 32'(m_addr));
        chk("out_instr", out_instr, m_instr);
      end
    end
    if (rst) begin
      m_known = 1; m_done = 0; m_lp = 0; m_err = 0; m_acc = 0; m_dr = 0;
    end else if (m_known) begin
      if (m_done && start) begin
        m_done = 0; m_lp = 0; m_err = 0; m_acc = 0; m_dr = 0;
      end else begin
        lp_old = m_lp;
        if (drn) m_dr++;
        if (acc) begin
          if (in_kind <= 9) begin
            m_instr = ref_encode(in_kind, in_rs, in_rt, in_rd, in_imm);
            m_addr  = ((BASE + m_acc) % NW) * 4;
            m_acc++;
          end else begin
            m_err = 1;
          end
          if (in_last) m_lp = 1;
        end
        if (!m_done && lp_old && (!ov || drn)) m_done = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; start = 0; in_last = 0;
  endtask

  task automatic req(input int kind, input int rs, input int rt, input int rd,
                     input int imm, input bit last);
    in_valid = 1;
    in_kind  = 4'(kind);
    in_rs    = 5'(rs);
    in_rt    = 5'(rt);
    in_rd    = 5'(rd);
    in_imm   = 16'(imm);
    in_last  = last;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    int exp_addr[6];
    exp_addr = '{0, 4, 8, 12, 0, 4};

    rst = 1;
    tick();
    tick();
    rst = 0;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_addr", 32'(out_addr), 32'd0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);

    // add
    out_ready = 1;
    req(1, 1, 2, 3, 0, 0);
    tick();
    chk("add instr", out_instr, 32'h00221820);
    chk("add addr", 32'(out_addr), 32'd0);
    idle();
    tick();
    chk("add count", 32'(count), 32'd1);

    // lw / sw back to back
    do_reset();
    req(6, 29, 8, 0, 4, 0);
    tick();
    chk("lw instr", out_instr, 32'h8FA80004);
    chk("lw addr", 32'(out_addr), 32'd0);
    chk("lw in_ready", 32'(in_ready), 32'd1);
    req(7, 0, 9, 0, 8, 0);
    tick();
    chk("sw instr", out_instr, 32'hAC090008);
    chk("sw addr", 32'(out_addr), 32'd4);
    chk("sw valid", 32'(out_valid), 32'd1);
    idle();
    tick();

    // beq under backpressure
    do_reset();
    out_ready = 0;
    req(8, 1, 2, 0, 16'hFFFF, 0);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("beq stall instr", out_instr, 32'h1022FFFF);
      chk("beq stall in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1;
    #1;
    chk("beq release in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("beq drained", 32'(out_valid), 32'd0);
    chk("beq count", 32'(count), 32'd1);

    // illegal kind then addi
    do_reset();
    req(12, 3, 4, 5, 77, 0);
    tick();
    chk("illegal err", 32'(err), 32'd1);
    chk("illegal no word", 32'(out_valid), 32'd0);
    req(9, 0, 8, 0, 5, 0);
    tick();
    chk("addi instr", out_instr, 32'h20080005);
    chk("addi addr", 32'(out_addr), 32'd0);
    idle();
    tick();

    // nops through an address wrap, ending the program
    do_reset();
    for (int i = 0; i < 6; i++) begin
      req(0, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
          $urandom_range(0, 65535), i == 5);
      tick();
      chk("nop addr", 32'(out_addr), 32'(exp_addr[i]));
      chk("nop instr", out_instr, 32'h0);
    end
    idle();
    tick();
    chk("end done", 32'(done), 32'd1);
    chk("end in_ready", 32'(in_ready), 32'd0);
    chk("end count", 32'(count), 32'd4);
    chk("end wrapped", 32'(wrapped), 32'd1);
    start = 1;
    tick();
    start = 0;
    chk("start done", 32'(done), 32'd0);
    chk("start count", 32'(count), 32'd0);
    chk("start wrapped", 32'(wrapped), 32'd0);
    chk("start out_addr", 32'(out_addr), 32'd0);

    // reset discards a pending word
    do_reset();
    out_ready = 0;
    req(2, 6, 7, 5, 0, 0);
    tick();
    chk("sub instr", out_instr, 32'h00C72822);
    idle();
    rst = 1;
    tick();
    rst = 0;
    chk("rst discard valid", 32'(out_valid), 32'd0);
    chk("rst discard count", 32'(count), 32'd0);
    out_ready = 1;
    tick();
    tick();
    chk("discarded never out", 32'(out_valid), 32'd0);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 599) == 0);
      if (m_done) begin
        in_valid = 0;
        in_last  = 0;
        start    = ($urandom_range(0, 3) == 0);
      end else begin
        start    = ($urandom_range(0, 49) == 0);
        in_valid = !m_lp && ($urandom_range(0, 2) != 0);
        in_kind  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                              : 4'($urandom_range(0, 9));
        in_rs    = 5'($urandom_range(0, 31));
        in_rt    = 5'($urandom_range(0, 31));
        in_rd    = 5'($urandom_range(0, 31));
        in_imm   = 16'($urandom_range(0, 65535));
        in_last  = ($urandom_range(0, 24) == 0);
      end
      tick();
    end
    idle();
    rst = 0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

- Sequential MIPS instruction encoder: the inverse of the main control/ALU-control decode path.
- Accepts symbolic instruction requests (kind plus register and immediate fields) over a valid/ready handshake.
- Emits one 32-bit machine word per legal request, paired with a sequential word-aligned byte address, for loading instruction memory in lab testbenches and boot loaders.
- Supports exactly the instruction set the datapath decodes: nop, add, sub, and, or, slt, lw, sw, beq, addi.

## Interface
Parameters:
- ADDR_W, 8: word-index width; the address space is 2^ADDR_W words.
- BASE_IDX, 0: word index loaded on reset and on `start`.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; leaves DONE and begins a new program.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request this cycle.
- in_kind  in  4  0 nop, 1 add, 2 sub, 3 and, 4 or, 5 slt, 6 lw, 7 sw, 8 beq, 9 addi; 10–15 illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  16  immediate or branch offset; passed through unmodified.
- in_last  in  1  marks the final request of the program.
- out_valid  out  1  word held on out_*.
- out_ready  in  1  consumer takes the word.
- out_addr  out  ADDR_W+2  byte address, equal to {idx, 2'b00}.
- out_instr  out  32  encoded word.
- done  out  1  high while in DONE.
- err  out  1  sticky; set by an illegal kind.
- wrapped  out  1  sticky; set when idx wraps.
- count  out  ADDR_W+1  words emitted since rst or `start`; saturates at 2^ADDR_W.

## Operation
States: RUN and DONE.

Word formats:
- R-type (kinds 1–5): {6'b000000, rs, rt, rd, 5'b00000, funct}. funct values: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- I-type: {op, rs, rt, imm}. op values: lw 100011, sw 101011, beq 000100, addi 001000.
- nop (kind 0): 32'h00000000, regardless of the field inputs.

Handshake and acceptance:
- in_ready = (state == RUN) && (!out_valid || out_ready).
- A request is accepted on the cycle where in_valid && in_ready.
- Legal accept: load the output register (out_valid=1, out_instr, out_addr={idx,2'b00}).
- The output register holds steady while out_valid && !out_ready.

Output drain (out_valid && out_ready):
- idx increments, wrapping modulo 2^ADDR_W.
- count increments, saturating at 2^ADDR_W.
- Wrap from 2^ADDR_W−1 to 0 sets `wrapped`.
- A new word may load in the same cycle as a drain, giving back-to-back throughput of 1 word/cycle.

Illegal kind (10–15):
- Accepted but not emitted: idx unchanged, err set.
- The output register is cleared only if it was draining that cycle.

in_last:
- Accepting any request with in_last=1 (legal or illegal) sets an internal last_pending flag.
- RUN→DONE occurs when last_pending is set and the output register is empty, or is draining that cycle.
- For an illegal last request with the output register empty, the transition happens on the cycle after accept.

DONE:
- in_ready=0, done=1.
- A `start` pulse returns to RUN and sets idx=BASE_IDX, count=0, err=0, wrapped=0, last_pending=0.
- `start` while in RUN is ignored.

## Timing
- All outputs are registered except in_ready, which is combinational from state, out_valid and out_ready.
- Latency: an accept at edge N puts the word on out_* after edge N, visible in cycle N+1.
- Reset values: out_valid=0, out_instr=0, out_addr={BASE_IDX,2'b00}, done=0, err=0, wrapped=0, count=0, state=RUN, idx=BASE_IDX.
- rst has priority over everything, including `start` and the handshakes. A pending word is discarded on reset and never emitted.
- in_kind and the field inputs are sampled only on accept; they are don't-care otherwise.

## Test plan
- add rs=1 rt=2 rd=3, out_ready=1 → out_instr=0x00221820, out_addr=0, count=1 one cycle later.
- lw rs=29 rt=8 imm=4, then sw rs=0 rt=9 imm=8, issued back-to-back → 0x8FA80004 @0, then 0xAC090008 @4, on consecutive cycles; in_ready stays 1.
- beq rs=1 rt=2 imm=0xFFFF with out_ready held 0 for 3 cycles → in_ready=0 and out_instr stable at 0x1022FFFF through the stall; the word drains on the cycle out_ready=1.
- kind=12 followed by addi rs=0 rt=8 imm=5 → err=1; no word for kind 12; 0x20080005 at out_addr=0.
- ADDR_W=2: 5 nops with the last one carrying in_last → addresses 0, 4, 8, 12, 0; wrapped=1; count=4 (saturated); done=1 with in_ready=0 after the last drain. A `start` pulse then clears done, count, err and wrapped, and restores out_addr to 0.
- rst asserted while sub rs=6 rt=7 rd=5 (0x00C72822) is pending with out_ready=0 → next cycle out_valid=0 and count=0, and that word never appears.
